// File: rtl/npc_pkg.sv
// Shared types and encodings for the NPC RV32 sequencer.
// Used by npc_seq_ctrl and npc_imm_gen.
package npc_pkg;

  typedef enum logic [2:0] {
    F_REQ,
    F_WAIT,
    DEC,
    EXE,
    WB,
    HALT
  } state_e;

  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam int ALU_OP_AUIPC = 0;
  localparam int ALU_OP_LUI   = 1;
  localparam int ALU_OP_JAL   = 2;
  localparam int ALU_OP_JALR  = 3;
  localparam int ALU_OP_ADDI  = 4;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/npc_seq_ctrl_if.sv
// Fetch, register-file and ALU signals of the NPC sequencer.
// master = sequencer side, slave = fetch/RF/ALU side.
interface npc_seq_ctrl_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_op;
  logic [31:0] alu_imm;
  logic [31:0] alu_src1;
  logic [31:0] alu_pc;
  logic [31:0] alu_result;
  logic [31:0] alu_next_pc;
  logic [31:0] pc;
  logic        halt;
  logic        illegal;

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_inst,
    output rf_raddr, rf_we, rf_waddr, rf_wdata,
    input  rf_rdata,
    output alu_op, alu_imm, alu_src1, alu_pc,
    input  alu_result, alu_next_pc,
    output pc, halt, illegal
  );

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_inst,
    input  rf_raddr, rf_we, rf_waddr, rf_wdata,
    output rf_rdata,
    input  alu_op, alu_imm, alu_src1, alu_pc,
    output alu_result, alu_next_pc,
    input  pc, halt, illegal
  );

endinterface

// File: rtl/npc_imm_gen.sv
// Combinational decode: instruction word -> immediate, one-hot ALU op,
// illegal flag. EBREAK decodes as legal with no ALU op.
module npc_imm_gen
  import npc_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [31:0] imm_o,
  output logic [31:0] alu_op_o,
  output logic        illegal_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_u;
  logic [31:0] imm_i;
  logic [31:0] imm_j;
  logic        is_auipc;
  logic        is_lui;
  logic        is_jal;
  logic        is_jalr;
  logic        is_addi;
  logic        is_ebrk;

  assign opc = ir_i[6:0];
  assign f3  = ir_i[14:12];

  assign imm_u = {ir_i[31:12], 12'b0};
  assign imm_i = {{20{ir_i[31]}}, ir_i[31:20]};
  assign imm_j = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12],
                  ir_i[20], ir_i[30:21], 1'b0};

  assign is_auipc = opc == OPC_AUIPC;
  assign is_lui   = opc == OPC_LUI;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR && f3 == 3'b000;
  assign is_addi  = opc == OPC_OPIMM && f3 == 3'b000;
  assign is_ebrk  = ir_i == EBREAK_INST;

  always_comb begin
    imm_o     = '0;
    alu_op_o  = '0;
    illegal_o = 1'b0;
    unique case (1'b1)
      is_auipc: begin
        imm_o = imm_u;
        alu_op_o[ALU_OP_AUIPC] = 1'b1;
      end
      is_lui: begin
        imm_o = imm_u;
        alu_op_o[ALU_OP_LUI] = 1'b1;
      end
      is_jal: begin
        imm_o = imm_j;
        alu_op_o[ALU_OP_JAL] = 1'b1;
      end
      is_jalr: begin
        imm_o = imm_i;
        alu_op_o[ALU_OP_JALR] = 1'b1;
      end
      is_addi: begin
        imm_o = imm_i;
        alu_op_o[ALU_OP_ADDI] = 1'b1;
      end
      is_ebrk: begin
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the NPC ALU.
// Optional NPC_RETIRE_CNT_EN adds retire_cnt/retire_pc outputs.
module npc_seq_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned FETCH_TMO = 16
) (
  input  logic clk,
  input  logic rst,
  npc_seq_ctrl_if.master bus
`ifdef NPC_RETIRE_CNT_EN
  ,
  output logic [63:0] retire_cnt,
  output logic [31:0] retire_pc
`endif
);

  localparam logic [31:0] TMO_LAST = FETCH_TMO - 1;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] src1_q;
  logic [31:0] imm_q;
  logic [31:0] op_q;
  logic [31:0] res_q;
  logic [31:0] tgt_q;
  logic        we_q;
  logic        halt_q;
  logic        illegal_q;
  logic [31:0] tmo_q;

  logic [31:0] dec_imm;
  logic [31:0] dec_op;
  logic        dec_ill;
  logic [31:0] pc_d;

  npc_imm_gen u_imm_gen (
    .ir_i      (ir_q),
    .imm_o     (dec_imm),
    .alu_op_o  (dec_op),
    .illegal_o (dec_ill)
  );

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (op_q[ALU_OP_JAL])
      pc_d = tgt_q;
    else if (op_q[ALU_OP_JALR])
      pc_d = tgt_q & ~32'h1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= F_REQ;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      src1_q    <= '0;
      imm_q     <= '0;
      op_q      <= '0;
      res_q     <= '0;
      tgt_q     <= '0;
      we_q      <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      unique case (state_q)
        F_REQ: begin
          if (bus.if_req_ready) begin
            tmo_q   <= '0;
            state_q <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (bus.if_rsp_valid) begin
            ir_q    <= bus.if_rsp_inst;
            state_q <= DEC;
          end else if (FETCH_TMO != 0 && tmo_q == TMO_LAST) begin
            illegal_q <= 1'b1;
            halt_q    <= 1'b1;
            state_q   <= HALT;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        DEC: begin
          src1_q <= (ir_q[19:15] == 5'd0) ? 32'd0 : bus.rf_rdata;
          imm_q  <= dec_imm;
          if (ir_q == EBREAK_INST) begin
            halt_q  <= 1'b1;
            state_q <= HALT;
          end else if (dec_ill) begin
            illegal_q <= 1'b1;
            halt_q    <= 1'b1;
            state_q   <= HALT;
          end else begin
            op_q    <= dec_op;
            state_q <= EXE;
          end
        end
        EXE: begin
          res_q   <= bus.alu_result;
          tgt_q   <= bus.alu_next_pc;
          we_q    <= ir_q[11:7] != 5'd0;
          state_q <= WB;
        end
        WB: begin
          we_q    <= 1'b0;
          op_q    <= '0;
          pc_q    <= pc_d;
          state_q <= F_REQ;
        end
        HALT: begin
        end
        default: state_q <= HALT;
      endcase
    end
  end

`ifdef NPC_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;
  logic [31:0] retire_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= '0;
      retire_pc_q  <= '0;
    end else if (state_q == WB) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
      retire_pc_q  <= pc_q;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign retire_pc  = retire_pc_q;
`endif

  // Request is a pure function of state, masked while reset is held.
  assign bus.if_req_valid = (state_q == F_REQ) && !rst;
  assign bus.if_addr      = pc_q;
  assign bus.rf_raddr     = ir_q[19:15];
  assign bus.rf_we        = we_q;
  assign bus.rf_waddr     = ir_q[11:7];
  assign bus.rf_wdata     = res_q;
  assign bus.alu_op       = op_q;
  assign bus.alu_imm      = imm_q;
  assign bus.alu_src1     = src1_q;
  assign bus.alu_pc       = pc_q;
  assign bus.pc           = pc_q;
  assign bus.halt         = halt_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed and random instruction streams for npc_seq_ctrl, checked
// against an instruction-level model of AUIPC/LUI/JAL/JALR/ADDI.
module tb_npc_seq_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] last_wdata;
  logic        last_we;
  logic [31:0] alu_res;
  logic [31:0] alu_npc;

  npc_seq_ctrl_if ifc ();

`ifdef NPC_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
  logic [31:0] retire_pc;
`endif

  npc_seq_ctrl #(
    .RESET_PC  (RPC),
    .FETCH_TMO (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
`ifdef NPC_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt),
    .retire_pc  (retire_pc)
`endif
  );

  always #5 clk = ~clk;

  // Register file: x0 returns junk so the sequencer must mask it.
  assign ifc.rf_rdata = (ifc.rf_raddr == 5'd0) ? 32'hDEAD_BEEF
                                               : m_regs[ifc.rf_raddr];

  // Stand-in ALU.
  always_comb begin
    alu_res = 32'h0;
    alu_npc = ifc.alu_pc + 32'd4;
    if (ifc.alu_op[0]) begin
      alu_res = ifc.alu_pc + ifc.alu_imm;
    end else if (ifc.alu_op[1]) begin
      alu_res = ifc.alu_imm;
    end else if (ifc.alu_op[2]) begin
      alu_res = ifc.alu_pc + 32'd4;
      alu_npc = ifc.alu_pc + ifc.alu_imm;
    end else if (ifc.alu_op[3]) begin
      alu_res = ifc.alu_pc + 32'd4;
      alu_npc = ifc.alu_src1 + ifc.alu_imm;
    end else if (ifc.alu_op[4]) begin
      alu_res = ifc.alu_src1 + ifc.alu_imm;
    end
  end
  assign ifc.alu_result  = alu_res;
  assign ifc.alu_next_pc = alu_npc;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.if_req_ready = 1'b0;
    ifc.if_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = RPC;
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!ifc.if_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", ifc.if_req_valid, 1);
    chk("if_addr", ifc.if_addr, m_pc);
  endtask

  // Ends at the negedge where the instruction sits in DEC.
  task automatic fetch(input logic [31:0] inst, input int rw,
                       input int pw);
    wait_req();
    for (int i = 0; i < rw; i++) begin
      @(negedge clk);
      chk("hold_valid", ifc.if_req_valid, 1);
      chk("hold_addr", ifc.if_addr, m_pc);
    end
    ifc.if_req_ready = 1'b1;
    ifc.if_rsp_valid = 1'b1;
    ifc.if_rsp_inst  = 32'hFFFF_FFFF;
    @(negedge clk);
    ifc.if_req_ready = 1'b0;
    ifc.if_rsp_valid = 1'b0;
    chk("wait_noreq", ifc.if_req_valid, 0);
    for (int i = 0; i < pw; i++) begin
      @(negedge clk);
      chk("wait_noreq", ifc.if_req_valid, 0);
    end
    ifc.if_rsp_valid = 1'b1;
    ifc.if_rsp_inst  = inst;
    @(negedge clk);
    ifc.if_rsp_valid = 1'b0;
    ifc.if_rsp_inst  = $urandom;
  endtask

  task automatic run_inst(input logic [31:0] inst, input int rw,
                          input int pw);
    logic [31:0] e_op, e_imm, e_s1, e_res, e_npc;
    logic [31:0] i_imm, u_imm, j_imm;
    logic [4:0]  rd, rs1;
    rd    = inst[11:7];
    rs1   = inst[19:15];
    e_s1  = (rs1 == 5'd0) ? 32'd0 : m_regs[rs1];
    i_imm = 32'($signed(inst[31:20]));
    u_imm = inst & 32'hFFFF_F000;
    j_imm = 32'($signed({inst[31], inst[19:12], inst[20],
                         inst[30:21], 1'b0}));
    e_npc = m_pc + 32'd4;
    case (inst[6:0])
      7'b0010111: begin
        e_op = 32'h1; e_imm = u_imm; e_res = m_pc + u_imm;
      end
      7'b0110111: begin
        e_op = 32'h2; e_imm = u_imm; e_res = u_imm;
      end
      7'b1101111: begin
        e_op = 32'h4; e_imm = j_imm; e_res = m_pc + 32'd4;
        e_npc = m_pc + j_imm;
      end
      7'b1100111: begin
        e_op = 32'h8; e_imm = i_imm; e_res = m_pc + 32'd4;
        e_npc = (e_s1 + i_imm) & 32'hFFFF_FFFE;
      end
      default: begin
        e_op = 32'h10; e_imm = i_imm; e_res = e_s1 + i_imm;
      end
    endcase
    fetch(inst, rw, pw);
    chk("dec_raddr", {27'b0, ifc.rf_raddr}, {27'b0, rs1});
    chk("dec_we", ifc.rf_we, 0);
    @(negedge clk);
    chk("exe_op", ifc.alu_op, e_op);
    chk("exe_imm", ifc.alu_imm, e_imm);
    chk("exe_src1", ifc.alu_src1, e_s1);
    chk("exe_pc", ifc.alu_pc, m_pc);
    chk("exe_we", ifc.rf_we, 0);
    @(negedge clk);
    chk("wb_we", ifc.rf_we, rd != 5'd0);
    chk("wb_waddr", {27'b0, ifc.rf_waddr}, {27'b0, rd});
    chk("wb_wdata", ifc.rf_wdata, e_res);
    last_wdata = ifc.rf_wdata;
    last_we    = ifc.rf_we;
    if (rd != 5'd0) m_regs[rd] = e_res;
    m_pc = e_npc;
    @(negedge clk);
    chk("next_pc", ifc.pc, m_pc);
    chk("op_clr", ifc.alu_op, 0);
    chk("post_we", ifc.rf_we, 0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r, j;
    logic [4:0]  rd, rs1;
    int          k;
    k   = int'($urandom_range(0, 4));
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    r   = $urandom;
    j   = $urandom;
    case (k)
      0: return {r[31:12], rd, 7'b0010111};
      1: return {r[31:12], rd, 7'b0110111};
      2: return {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
      3: return {r[11:0], rs1, 3'b000, rd, 7'b1100111};
      default: return {r[11:0], rs1, 3'b000, rd, 7'b0010011};
    endcase
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    rst = 1'b1;
    ifc.if_req_ready = 1'b0;
    ifc.if_rsp_valid = 1'b0;
    ifc.if_rsp_inst  = 32'h0;
    m_pc = RPC;
    last_wdata = 32'h0;
    last_we    = 1'b0;
    m_regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) m_regs[i] = $urandom;

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", ifc.if_req_valid, 0);
    chk("rst_pc", ifc.pc, RPC);
    chk("rst_op", ifc.alu_op, 0);
    chk("rst_imm", ifc.alu_imm, 0);
    chk("rst_src1", ifc.alu_src1, 0);
    chk("rst_we", ifc.rf_we, 0);
    chk("rst_halt", ifc.halt, 0);
    chk("rst_ill", ifc.illegal, 0);
    rst = 1'b0;
    #1;

    run_inst(32'h0050_0093, 0, 0);
    chk("addi_wdata", last_wdata, 32'd5);
    chk("addi_pc", ifc.pc, 32'h8000_0004);
    run_inst(32'h1234_5137, 0, 0);
    chk("lui_wdata", last_wdata, 32'h1234_5000);
    run_inst(32'h0000_1197, 0, 0);
    chk("auipc_wdata", last_wdata, 32'h8000_1008);

    do_reset();
    run_inst(32'h0100_00EF, 0, 0);
    chk("jal_wdata", last_wdata, 32'h8000_0004);
    chk("jal_pc", ifc.pc, 32'h8000_0010);
    run_inst(32'h0030_8067, 3, 2);
    chk("jalr_pc", ifc.pc, 32'h8000_0006);
    chk("jalr_we", last_we, 0);

    fetch(32'h0010_0073, 0, 0);
    chk("ebrk_dec_halt", ifc.halt, 0);
    @(negedge clk);
    chk("ebrk_halt", ifc.halt, 1);
    chk("ebrk_ill", ifc.illegal, 0);
    chk("ebrk_pc", ifc.pc, 32'h8000_0006);
    for (int i = 0; i < 3; i++) begin
      chk("ebrk_we", ifc.rf_we, 0);
      chk("ebrk_noreq", ifc.if_req_valid, 0);
      @(negedge clk);
    end

    do_reset();
    fetch(32'hFFFF_FFFF, 0, 1);
    @(negedge clk);
    chk("ill_halt", ifc.halt, 1);
    chk("ill_ill", ifc.illegal, 1);
    chk("ill_pc", ifc.pc, RPC);
    chk("ill_we", ifc.rf_we, 0);
    @(negedge clk);
    chk("ill_noreq", ifc.if_req_valid, 0);

    do_reset();
    fetch(32'h0070_0293, 1, 1);
    @(negedge clk);
    chk("abort_exe_op", ifc.alu_op, 32'h10);
    rst = 1'b1;
    #1;
    chk("abort_pc", ifc.pc, RPC);
    chk("abort_we", ifc.rf_we, 0);
    chk("abort_op", ifc.alu_op, 0);
    chk("abort_noreq", ifc.if_req_valid, 0);
    ifc.if_rsp_valid = 1'b1;
    ifc.if_rsp_inst  = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_we_hold", ifc.rf_we, 0);
    end
    rst = 1'b0;
    m_pc = RPC;
    #1;
    chk("abort_req", ifc.if_req_valid, 1);
    chk("abort_addr", ifc.if_addr, RPC);
    @(negedge clk);
    chk("late_rsp_halt", ifc.halt, 0);
    chk("late_rsp_req", ifc.if_req_valid, 1);
    ifc.if_rsp_valid = 1'b0;
    run_inst(32'h0070_0293, 0, 0);
    chk("after_abort_wdata", last_wdata, 32'd7);

    wait_req();
    ifc.if_req_ready = 1'b1;
    @(negedge clk);
    ifc.if_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_early", ifc.halt, 0);
      @(negedge clk);
    end
    chk("tmo_halt", ifc.halt, 1);
    chk("tmo_ill", ifc.illegal, 1);
    chk("tmo_we", ifc.rf_we, 0);

    do_reset();
    for (int n = 0; n < 40; n++) begin
      run_inst(rand_inst(), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
